// File: rtl/axi_hp_arb_pkg.sv
// axi_hp_arb_pkg: shared types and defaults for the two-writer HP write arbiter
package axi_hp_arb_pkg;
   localparam int ORDER_DEPTH_DEF = 4;
   typedef enum logic {AW_IDLE, AW_HOLD} aw_state_t;
   typedef struct packed {
      logic [3:0] len;
      logic [2:0] size;
      logic [1:0] burst;
      logic [3:0] cache;
   } aw_attr_t;
endpackage

// File: rtl/axi_hp_arb_order_fifo.sv
// axi_hp_arb_order_fifo: source index of each granted burst, in grant order, until its W data completes
module axi_hp_arb_order_fifo #(
   parameter int DEPTH = 4
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic dout,
   output logic full,
   output logic empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   always_comb begin
      do_push = push && !full;
      do_pop = pop && !empty;
      mem_d = mem_q;
      if (do_push) mem_d[wptr_q] = din;
      wptr_d = wptr_q + PW'(do_push);
      rptr_d = rptr_q + PW'(do_pop);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         mem_q <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q <= cnt_d;
      end
   end
   assign full = cnt_q == CW'(DEPTH);
   assign empty = cnt_q == '0;
   assign dout = mem_q[rptr_q];
endmodule

// File: rtl/axi_hp_write_arbiter.sv
// axi_hp_write_arbiter: round-robin share of one AXI3 HP write port between two 16-beat burst writers
module axi_hp_write_arbiter
   import axi_hp_arb_pkg::*;
#(
   parameter int AXI_ID_WIDTH   = 6,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int ORDER_DEPTH    = ORDER_DEPTH_DEF
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [AXI_ID_WIDTH-1:0]     s0_axi_awid,
   input  logic [AXI_ADDR_WIDTH-1:0]   s0_axi_awaddr,
   input  logic [3:0]                  s0_axi_awlen,
   input  logic [2:0]                  s0_axi_awsize,
   input  logic [1:0]                  s0_axi_awburst,
   input  logic [3:0]                  s0_axi_awcache,
   input  logic                        s0_axi_awvalid,
   output logic                        s0_axi_awready,
   input  logic [AXI_ID_WIDTH-1:0]     s0_axi_wid,
   input  logic [AXI_DATA_WIDTH-1:0]   s0_axi_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] s0_axi_wstrb,
   input  logic                        s0_axi_wlast,
   input  logic                        s0_axi_wvalid,
   output logic                        s0_axi_wready,
   output logic                        s0_axi_bvalid,
   input  logic                        s0_axi_bready,
   input  logic [AXI_ID_WIDTH-1:0]     s1_axi_awid,
   input  logic [AXI_ADDR_WIDTH-1:0]   s1_axi_awaddr,
   input  logic [3:0]                  s1_axi_awlen,
   input  logic [2:0]                  s1_axi_awsize,
   input  logic [1:0]                  s1_axi_awburst,
   input  logic [3:0]                  s1_axi_awcache,
   input  logic                        s1_axi_awvalid,
   output logic                        s1_axi_awready,
   input  logic [AXI_ID_WIDTH-1:0]     s1_axi_wid,
   input  logic [AXI_DATA_WIDTH-1:0]   s1_axi_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] s1_axi_wstrb,
   input  logic                        s1_axi_wlast,
   input  logic                        s1_axi_wvalid,
   output logic                        s1_axi_wready,
   output logic                        s1_axi_bvalid,
   input  logic                        s1_axi_bready,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [3:0]                  m_axi_awlen,
   output logic [2:0]                  m_axi_awsize,
   output logic [1:0]                  m_axi_awburst,
   output logic [3:0]                  m_axi_awcache,
   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_wid,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                        m_axi_wlast,
   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
   input  logic                        m_axi_bvalid,
   output logic                        m_axi_bready,
   output logic [31:0]                 sts_bursts0,
   output logic [31:0]                 sts_bursts1
);
   localparam int IL = AXI_ID_WIDTH - 1;
   aw_state_t state_q, state_d;
   logic last_q, last_d;
   logic [AXI_ID_WIDTH-1:0] awid_q, awid_d;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   aw_attr_t attr_q, attr_d;
   logic [31:0] bursts0_q, bursts0_d, bursts1_q, bursts1_d;
   logic full, empty, head, push, pop, gnt, req, w_act, b_src;
   logic [AXI_ID_WIDTH-1:0] wid_sel;
   logic unused_ok;
   // Both requesting: the one not served last; otherwise whoever asks.
   assign gnt = (s0_axi_awvalid && s1_axi_awvalid) ? !last_q : s1_axi_awvalid;
   assign req = aresetn && !full && (s0_axi_awvalid || s1_axi_awvalid);
   always_comb begin
      state_d = state_q;
      last_d = last_q;
      awid_d = awid_q;
      awaddr_d = awaddr_q;
      attr_d = attr_q;
      push = 1'b0;
      m_axi_awvalid = 1'b0;
      s0_axi_awready = 1'b0;
      s1_axi_awready = 1'b0;
      case (state_q)
         AW_IDLE: if (req) begin
            push = 1'b1;
            last_d = gnt;
            state_d = AW_HOLD;
            s0_axi_awready = !gnt;
            s1_axi_awready = gnt;
            awid_d = {gnt, gnt ? s1_axi_awid[IL-1:0] : s0_axi_awid[IL-1:0]};
            awaddr_d = gnt ? s1_axi_awaddr : s0_axi_awaddr;
            attr_d = gnt ? {s1_axi_awlen, s1_axi_awsize, s1_axi_awburst, s1_axi_awcache}
                         : {s0_axi_awlen, s0_axi_awsize, s0_axi_awburst, s0_axi_awcache};
         end
         AW_HOLD: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) state_d = AW_IDLE;
         end
         default: state_d = AW_IDLE;
      endcase
   end
   always_comb begin
      bursts0_d = bursts0_q + 32'(pop && !head);
      bursts1_d = bursts1_q + 32'(pop && head);
   end
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= AW_IDLE;
         last_q <= 1'b1;
         awid_q <= '0;
         awaddr_q <= '0;
         attr_q <= '0;
         bursts0_q <= '0;
         bursts1_q <= '0;
      end else begin
         state_q <= state_d;
         last_q <= last_d;
         awid_q <= awid_d;
         awaddr_q <= awaddr_d;
         attr_q <= attr_d;
         bursts0_q <= bursts0_d;
         bursts1_q <= bursts1_d;
      end
   end
   axi_hp_arb_order_fifo #(.DEPTH(ORDER_DEPTH)) u_order (
      .aclk   (aclk),
      .aresetn(aresetn),
      .push   (push),
      .din    (gnt),
      .pop    (pop),
      .dout   (head),
      .full   (full),
      .empty  (empty)
   );
   assign m_axi_awid = awid_q;
   assign m_axi_awaddr = awaddr_q;
   assign m_axi_awlen = attr_q.len;
   assign m_axi_awsize = attr_q.size;
   assign m_axi_awburst = attr_q.burst;
   assign m_axi_awcache = attr_q.cache;
   // W follows the oldest granted burst; the other writer is simply stalled.
   assign w_act = aresetn && !empty;
   assign wid_sel = head ? s1_axi_wid : s0_axi_wid;
   assign m_axi_wid = {head, wid_sel[IL-1:0]};
   assign m_axi_wdata = head ? s1_axi_wdata : s0_axi_wdata;
   assign m_axi_wstrb = head ? s1_axi_wstrb : s0_axi_wstrb;
   assign m_axi_wlast = head ? s1_axi_wlast : s0_axi_wlast;
   assign m_axi_wvalid = w_act && (head ? s1_axi_wvalid : s0_axi_wvalid);
   assign s0_axi_wready = w_act && !head && m_axi_wready;
   assign s1_axi_wready = w_act && head && m_axi_wready;
   assign pop = m_axi_wvalid && m_axi_wready && m_axi_wlast;
   assign b_src = m_axi_bid[IL];
   assign s0_axi_bvalid = aresetn && m_axi_bvalid && !b_src;
   assign s1_axi_bvalid = aresetn && m_axi_bvalid && b_src;
   assign m_axi_bready = b_src ? s1_axi_bready : s0_axi_bready;
   assign sts_bursts0 = bursts0_q;
   assign sts_bursts1 = bursts1_q;
   assign unused_ok = ^{s0_axi_awid[IL], s1_axi_awid[IL], wid_sel[IL], m_axi_bid[IL-1:0]};
endmodule
